// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, fetches one 32-bit word at a time from
// instruction memory over a req/ack handshake, and hands it to decode with a
// valid/ready handshake. Execute-stage redirects flush any fetch in flight.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   imem_req/addr    fetch request and word-aligned address (stable while req=1)
//   imem_ack/rdata   memory accept strobe and the fetched word in that cycle
//   redirect/target  taken branch/jump pulse and its new PC
//   instr_valid/rdy  decode handshake
//   instr/instr_pc   current instruction word and its address
//   pc_plus4         instr_pc + 4 (mod 2^32)
//   Op/func3/func7   decode fields sliced from instr
//   misalign_err     one-cycle pulse when a redirect target is not word-aligned
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  Op,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        mis_q, mis_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    mis_d   = redirect && (redirect_target[1:0] != 2'b00);

    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (kill_q) begin
            // Stale response for a pre-redirect address; pc already holds the target.
            kill_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (valid_q && instr_ready) begin
          pc_d    = ipc_q + 32'd4;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above, including a same-cycle consume.
    if (redirect) begin
      pc_d    = redirect_target & ~32'h3;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      state_d = FETCH;
      if (state_q == FETCH) begin
        if (imem_ack) begin
          // Request completed this cycle: drop it and idle one cycle before retargeting.
          kill_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // Request still outstanding: address must stay put until it is acked.
          kill_d = 1'b1;
        end
      end
    end

    // A new address is launched only when no request is left outstanding.
    addr_d = addr_q;
    if (state_d == FETCH && !(state_q == FETCH && !imem_ack))
      addr_d = pc_d;
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = addr_q;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = ipc_q;
  assign pc_plus4     = ipc_q + 32'd4;
  assign Op           = instr_q[6:0];
  assign func3        = instr_q[14:12];
  assign func7        = instr_q[31:25];
  assign misalign_err = mis_q;

endmodule
